lakespec_config_loader: RTL and testbench
=========================================

LAKESPEC_CONFIG_LOADER -- requirements
Module: lakespec_config_loader

Interface
REQ-001 Parameter CONFIG_WIDTH, default 550, width of the lakespec configuration vector.
REQ-002 Parameter WORD_WIDTH, default 32, width of one configuration word.
REQ-003 Parameter FLUSH_CYCLES, default 4, number of cycles flush is held high after a commit; legal range 1..255.
REQ-004 Derived NUM_WORDS = ceil(CONFIG_WIDTH/WORD_WIDTH), 18 at defaults; CNT_W = clog2(NUM_WORDS+1).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 cfg_start  input  1  single-cycle request to begin a configuration load.
REQ-009 cfg_word_valid  input  1  configuration word present on cfg_word_data.
REQ-010 cfg_word_data  input  WORD_WIDTH  configuration word, least-significant word first.
REQ-011 cfg_word_ready  output  1  loader accepts a word this cycle.
REQ-012 config_memory_size_550  output  CONFIG_WIDTH  committed configuration driven to lakespec.
REQ-013 flush  output  1  flush driven to lakespec.
REQ-014 cfg_done  output  1  configuration committed and flush complete; lakespec is running.
REQ-015 cfg_err  output  1  sticky protocol error flag.
REQ-016 word_count  output  CNT_W  number of words accepted in the current load.

Function
REQ-017 The loader SHALL implement states IDLE, LOAD, FLUSH, RUN; all outputs SHALL be driven from registers or decoded from the state register only, with no combinational path from inputs.
REQ-018 IDLE: cfg_word_ready=0, flush=0, cfg_done=0; cfg_start=1 SHALL move to LOAD next cycle, clearing word_count, the shadow register and cfg_err.
REQ-019 LOAD: cfg_word_ready=1; a word SHALL be accepted only when cfg_word_valid and cfg_word_ready are both 1 on a rising edge.
REQ-020 Accepted word k SHALL be written to shadow bits [k*WORD_WIDTH +: WORD_WIDTH], truncated at CONFIG_WIDTH-1; at defaults, word 17 contributes only its bits [5:0], and bits [31:6] are discarded.
REQ-021 word_count SHALL increment by 1 per accepted word and never exceed NUM_WORDS.
REQ-022 On the edge accepting word NUM_WORDS-1, the full shadow including that word SHALL be copied to config_memory_size_550 atomically, and the state SHALL move to FLUSH.
REQ-023 config_memory_size_550 SHALL change only on a commit edge; partial loads SHALL never be visible on it.
REQ-024 FLUSH: flush=1 and cfg_word_ready=0 for exactly FLUSH_CYCLES consecutive cycles, starting the cycle after the commit edge, then the state SHALL move to RUN.
REQ-025 RUN: cfg_done=1, flush=0, cfg_word_ready=0; cfg_start=1 SHALL move to LOAD per REQ-018, with cfg_done falling the next cycle and config_memory_size_550 retained until the next commit.
REQ-026 cfg_start asserted in LOAD or FLUSH SHALL be ignored for state purposes and SHALL set cfg_err; cfg_err remains 1 until cleared by a cfg_start accepted in IDLE or RUN.
REQ-027 cfg_word_valid asserted in IDLE, FLUSH or RUN SHALL be ignored (word dropped) and SHALL NOT set cfg_err.
REQ-028 LOAD has no timeout; the loader waits indefinitely for words, and cfg_word_valid gaps are legal.

Reset
REQ-029 While rst_n=0, asynchronously: state=IDLE, config_memory_size_550=0, shadow=0, word_count=0, flush=0, cfg_done=0, cfg_word_ready=0, cfg_err=0.
REQ-030 Reset asserted mid-LOAD or mid-FLUSH SHALL discard the load; after release the loader stays in IDLE until cfg_start.

Verification
REQ-031 Full load: start, 18 back-to-back words 0x00000001..0x00000012 -> output bit 0=1, bits[575:544] truncated to 6'h12, flush high on exactly cycles 1..4 after the 18th accept, cfg_done=1 on cycle 5.
REQ-032 Gapped load: valid deasserted every other cycle -> identical output to REQ-031, word_count steps 0..18, output stays 0 until the commit edge.
REQ-033 Start during LOAD after 5 words -> cfg_err=1, load continues, word_count=6 after the next accept, cfg_err cleared by a later start issued in RUN.
REQ-034 Reconfigure from RUN with all words 0xFFFFFFFF -> old config held through LOAD, then all 550 bits=1, second flush burst of 4 cycles.
REQ-035 rst_n pulsed low after 10 words -> all outputs 0 immediately, IDLE after release, valid words ignored until start.
REQ-036 Parameter FLUSH_CYCLES=1 -> flush high for exactly one cycle, and cfg_done=1 the following cycle.

Source files
------------

// File: rtl/lakespec_config_loader.sv
// Lakespec configuration loader: collects words into a shadow register,
// commits the full vector atomically, then holds flush for a fixed burst.
module lakespec_config_loader #(
  parameter int CONFIG_WIDTH = 550,
  parameter int WORD_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 4,
  localparam int NUM_WORDS   = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int CNT_W       = $clog2(NUM_WORDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic                    cfg_word_valid,
  input  logic [WORD_WIDTH-1:0]   cfg_word_data,
  output logic                    cfg_word_ready,
  output logic [CONFIG_WIDTH-1:0] config_memory_size_550,
  output logic                    flush,
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic [CNT_W-1:0]        word_count
);

  localparam int SH_W = NUM_WORDS * WORD_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [SH_W-1:0]         shadow_q, shadow_d;
  logic [CONFIG_WIDTH-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              fcnt_q, fcnt_d;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    last;

  assign accept = (state_q == S_LOAD) && cfg_word_valid;
  assign last   = (cnt_q == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      cfg_q    <= '0;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        if (cfg_start) begin
          state_d  = S_LOAD;
          shadow_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (cfg_start) err_d = 1'b1;
        if (accept) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (cnt_q == CNT_W'(k))
              shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = cfg_word_data;
          end
          cnt_d = cnt_q + CNT_W'(1);
          // Commit includes the word accepted on this same edge.
          if (last) begin
            state_d = S_FLUSH;
            cfg_d   = shadow_d[CONFIG_WIDTH-1:0];
            fcnt_d  = '0;
          end
        end
      end
      S_FLUSH: begin
        if (cfg_start) err_d = 1'b1;
        if (fcnt_q == 8'(FLUSH_CYCLES - 1)) state_d = S_RUN;
        else fcnt_d = fcnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_word_ready         = (state_q == S_LOAD);
  assign flush                  = (state_q == S_FLUSH);
  assign cfg_done               = (state_q == S_RUN);
  assign cfg_err                = err_q;
  assign word_count             = cnt_q;
  assign config_memory_size_550 = cfg_q;

endmodule

// File: tb/tb_lakespec_config_loader.sv
// Bench for lakespec_config_loader: two instances (flush burst 4 and 1)
// driven by shared stimulus and compared against a word-list model.
module tb_lakespec_config_loader;

  localparam int CW = 550;
  localparam int NW = 18;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        valid;
  logic [31:0] data;

  logic [1:0]    rdy, fl, dn, er;
  logic [CW-1:0] cf0, cf1;
  logic [4:0]    wc0, wc1;

  int n_cmp;
  int n_bad;

  int            fc     [2];
  int            m_load [2];
  int            m_fl   [2];
  int            m_run  [2];
  int            m_err  [2];
  int            m_n    [2];
  logic [31:0]   m_w    [2][NW];
  logic [CW-1:0] m_cfg  [2];

  lakespec_config_loader #(.FLUSH_CYCLES(4)) u_fc4 (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cfg_start              (start),
    .cfg_word_valid         (valid),
    .cfg_word_data          (data),
    .cfg_word_ready         (rdy[0]),
    .config_memory_size_550 (cf0),
    .flush                  (fl[0]),
    .cfg_done               (dn[0]),
    .cfg_err                (er[0]),
    .word_count             (wc0)
  );

  lakespec_config_loader #(.FLUSH_CYCLES(1)) u_fc1 (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cfg_start              (start),
    .cfg_word_valid         (valid),
    .cfg_word_data          (data),
    .cfg_word_ready         (rdy[1]),
    .config_memory_size_550 (cf1),
    .flush                  (fl[1]),
    .cfg_done               (dn[1]),
    .cfg_err                (er[1]),
    .word_count             (wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [575:0] got,
                     input logic [575:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_load[i] = 0;
      m_fl[i]   = 0;
      m_run[i]  = 0;
      m_err[i]  = 0;
      m_n[i]    = 0;
      m_cfg[i]  = '0;
    end
  endtask

  // One rising edge of the reference behaviour for instance i.
  task automatic m_step(input int i);
    logic [NW*32-1:0] big;
    if (m_load[i] != 0) begin
      if (start) m_err[i] = 1;
      if (valid) begin
        m_w[i][m_n[i]] = data;
        m_n[i]++;
        if (m_n[i] == NW) begin
          big = '0;
          for (int k = 0; k < NW; k++) big[k*32 +: 32] = m_w[i][k];
          m_cfg[i]  = big[CW-1:0];
          m_load[i] = 0;
          m_fl[i]   = fc[i];
        end
      end
    end else if (m_fl[i] > 0) begin
      if (start) m_err[i] = 1;
      m_fl[i]--;
      if (m_fl[i] == 0) m_run[i] = 1;
    end else if (start) begin
      m_load[i] = 1;
      m_run[i]  = 0;
      m_n[i]    = 0;
      m_err[i]  = 0;
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d ready", i), rdy[i], m_load[i] != 0);
      chk($sformatf("i%0d flush", i), fl[i], m_fl[i] > 0);
      chk($sformatf("i%0d done", i), dn[i], m_run[i] != 0);
      chk($sformatf("i%0d err", i), er[i], m_err[i] != 0);
      chk($sformatf("i%0d count", i), (i == 0) ? wc0 : wc1, m_n[i]);
      chk($sformatf("i%0d config", i), (i == 0) ? cf0 : cf1, m_cfg[i]);
    end
  endtask

  task automatic cyc(input logic s, input logic v, input logic [31:0] d);
    start = s;
    valid = v;
    data  = d;
    @(posedge clk);
    m_step(0);
    m_step(1);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic areset();
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    cmp_all();
    @(negedge clk);
    cmp_all();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    fc[0] = 4;
    fc[1] = 1;
    start = 1'b0;
    valid = 1'b0;
    data  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 32'hdead_beef);

    // Back-to-back full load of 1..18
    cyc(1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= NW; k++) cyc(1'b0, 1'b1, 32'(k));
    chk("full bit0", cf0[0], 1'b1);
    chk("full top", cf0[549:544], 6'h12);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("burst4 flush c%0d", c), fl[0], c <= 4);
      chk($sformatf("burst4 done c%0d", c), dn[0], c == 5);
      chk($sformatf("burst1 flush c%0d", c), fl[1], c == 1);
      chk($sformatf("burst1 done c%0d", c), dn[1], c >= 2);
      if (c < 5) cyc(1'b0, 1'b0, 32'h0);
    end

    // Gapped load from a fresh reset
    areset();
    cyc(1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= NW; k++) begin
      cyc(1'b0, 1'b0, $urandom);
      cyc(1'b0, 1'b1, 32'(k));
    end
    chk("gap top", cf0[549:544], 6'h12);
    repeat (5) cyc(1'b0, 1'b0, 32'h0);

    // Start issued mid-load
    cyc(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, $urandom);
    cyc(1'b1, 1'b0, 32'h0);
    chk("midload err", er[0], 1'b1);
    cyc(1'b0, 1'b1, $urandom);
    chk("midload count", wc0, 5'd6);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, $urandom);
    repeat (5) cyc(1'b0, 1'b0, 32'h0);

    // Reconfigure from RUN with all ones
    cyc(1'b1, 1'b0, 32'h0);
    chk("restart err clr", er[0], 1'b0);
    for (int k = 0; k < NW; k++) cyc(1'b0, 1'b1, 32'hffff_ffff);
    chk("all ones", cf0, {CW{1'b1}});
    repeat (5) cyc(1'b0, 1'b0, 32'h0);

    // Reset mid-load, then words ignored in IDLE
    cyc(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, $urandom);
    areset();
    chk("post-rst count", wc0, 5'd0);
    repeat (3) cyc(1'b0, 1'b1, $urandom);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) areset();
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
